// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stable-window debounce FSM,
// registered level plus one-cycle pressed/released/long_press pulses.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   button_raw  raw bouncy button level, active high, asynchronous
//   button_out  debounced level
//   pressed     one-cycle pulse on an accepted 0->1 change
//   released    one-cycle pulse on an accepted 1->0 change
//   long_press  one-cycle pulse once per press after LONG_TICKS held

module button_debouncer #(
  parameter int BOUNCE_TICKS = 120_000,
  parameter int LONG_TICKS   = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_out,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam int DW = $clog2(BOUNCE_TICKS) + 1;
  localparam int HW = $clog2(LONG_TICKS) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(BOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

  typedef enum logic [1:0] {
    S_REL     = 2'd0,
    S_MAYBE_P = 2'd1,
    S_PRESS   = 2'd2,
    S_MAYBE_R = 2'd3
  } state_e;

  state_e        state_q;
  logic          sync1_q;
  logic          sync2_q;
  logic [DW-1:0] db_q;
  logic [DW-1:0] db_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          button_q;
  logic          pressed_q;
  logic          released_q;
  logic          long_q;

  // Two-flop synchroniser; only sync2_q is seen by the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce counter increment and saturating hold counter increment.
  always_comb begin
    db_d   = db_q + DW'(1);
    hold_d = hold_q;
    if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REL;
      db_q       <= '0;
      hold_q     <= '0;
      button_q   <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
      case (state_q)
        S_REL: begin
          button_q <= 1'b0;
          if (sync2_q) begin
            state_q <= S_MAYBE_P;
            db_q    <= '0;
          end
        end
        S_MAYBE_P: begin
          if (!sync2_q) begin
            state_q <= S_REL;
            db_q    <= '0;
          end else if (db_q == DB_LAST) begin
            state_q   <= S_PRESS;
            button_q  <= 1'b1;
            pressed_q <= 1'b1;
            hold_q    <= '0;
          end else begin
            db_q <= db_d;
          end
        end
        S_PRESS: begin
          // Hold time keeps running through release glitches.
          hold_q <= hold_d;
          if (!sync2_q) begin
            state_q <= S_MAYBE_R;
            db_q    <= '0;
          end else if (hold_q == HOLD_LAST) begin
            long_q <= 1'b1;
          end
        end
        S_MAYBE_R: begin
          hold_q <= hold_d;
          if (sync2_q) begin
            state_q <= S_PRESS;
          end else if (db_q == DB_LAST) begin
            state_q    <= S_REL;
            button_q   <= 1'b0;
            released_q <= 1'b1;
          end else begin
            db_q <= db_d;
          end
        end
        default: begin
          state_q  <= S_REL;
          db_q     <= '0;
          hold_q   <= '0;
          button_q <= 1'b0;
        end
      endcase
    end
  end

  assign button_out = button_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues expected pulses
// with their cycle numbers, a negedge monitor pops and compares them.

module tb_button_debouncer;

  localparam int BT  = 50;
  localparam int LT  = 200;
  localparam int LAT = BT + 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic button_raw;
  logic button_out;
  logic pressed;
  logic released;
  logic long_press;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  ev_t exp_q[$];

  button_debouncer #(
    .BOUNCE_TICKS(BT),
    .LONG_TICKS(LT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_raw(button_raw),
    .button_out(button_out),
    .pressed(pressed),
    .released(released),
    .long_press(long_press)
  );

  always #42 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    int k;
    int n;
    ev_t e;
    n = int'(pressed) + int'(released) + int'(long_press);
    k = pressed ? 1 : released ? 2 : long_press ? 3 : 0;
    if (n > 1) chk("pulse_onehot", n, 1);
    if (k != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", k, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        if (k == 1) chk("level_after_press", int'(button_out), 1);
        if (k == 2) chk("level_after_release", int'(button_out), 0);
      end
    end
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missing_pulse_kind", 0, e.kind);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press for n cycles, release, then idle; expectations computed up front.
  task automatic press_hold(input int n, input int idle);
    int c;
    button_raw = 1'b1;
    c = cyc;
    push(1, c + LAT);
    if (LAT + LT <= n + 2) push(3, c + LAT + LT);
    push(2, c + n + LAT);
    wait_n(n);
    button_raw = 1'b0;
    wait_n(idle);
  endtask

  initial begin
    int c;
    rst = 1'b0;
    button_raw = 1'b1;

    // 1: reset values with the button held, then qualified press.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs",
          int'({button_out, pressed, released, long_press}), 0);
    end
    rst = 1'b1;
    c = cyc;
    push(1, c + LAT);
    wait_n(LAT - 1);
    chk("level_before_accept", int'(button_out), 0);
    wait_n(1);
    chk("level_at_accept", int'(button_out), 1);
    button_raw = 1'b0;
    c = cyc;
    push(2, c + LAT);
    wait_n(LAT + 5);
    chk("level_after_first_release", int'(button_out), 0);

    // 2: bounces shorter than the window are rejected.
    for (int i = 0; i < 10; i++) begin
      button_raw = ~button_raw;
      wait_n(10);
    end
    button_raw = 1'b0;
    wait_n(LAT + 5);
    chk("bounce_level", int'(button_out), 0);

    // 3: release glitch shorter than the window.
    button_raw = 1'b1;
    c = cyc;
    push(1, c + LAT);
    wait_n(100);
    button_raw = 1'b0;
    wait_n(30);
    button_raw = 1'b1;
    wait_n(50);
    chk("glitch_level", int'(button_out), 1);
    button_raw = 1'b0;
    c = cyc;
    push(2, c + LAT);
    wait_n(LAT + 5);
    chk("glitch_level_released", int'(button_out), 0);

    // 4: long press fires once.
    press_hold(400, LAT + 5);
    chk("long_level_released", int'(button_out), 0);

    // 5: two identical short presses.
    press_hold(100, LAT + 5);
    press_hold(100, LAT + 5);
    chk("short_level_released", int'(button_out), 0);

    // 6: reset mid-press, then re-qualified press.
    button_raw = 1'b1;
    c = cyc;
    push(1, c + LAT);
    wait_n(80);
    chk("mid_press_level", int'(button_out), 1);
    #10;
    rst = 1'b0;
    #1;
    chk("reset_drop_outputs",
        int'({button_out, pressed, released, long_press}), 0);
    wait_n(2);
    rst = 1'b1;
    c = cyc;
    push(1, c + LAT);
    wait_n(LAT + 5);
    chk("requalified_level", int'(button_out), 1);
    button_raw = 1'b0;
    c = cyc;
    push(2, c + LAT);
    wait_n(LAT + 5);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Upstream conditioning stage for the etch-a-sketch LED/colour logic. Takes one raw, bouncy, asynchronous push-button input and synchronises it to `clk`. It then qualifies every level change over a stable window and emits a clean level plus single-cycle press, release and long-press events. Downstream colour/mode logic consumes these directly. One instance per physical button; the instance on the mode button replaces any ad-hoc bounce counting downstream.

## Interface
- `BOUNCE_TICKS`, default 120_000: consecutive stable cycles required to accept a level change (10 ms at 12 MHz); legal range ≥ 1.
- `LONG_TICKS`, default 12_000_000: cycles held in the pressed state before `long_press` fires (1 s at 12 MHz); legal range ≥ 1.
- `clk`  input  1  system clock, 12 MHz.
- `rst`  input  1  reset; asynchronous, active-low.
- `button_raw`  input  1  raw button level, active-high, asynchronous to `clk`.
- `button_out`  output  1  debounced level, registered.
- `pressed`  output  1  one-cycle pulse on an accepted 0→1 change, registered.
- `released`  output  1  one-cycle pulse on an accepted 1→0 change, registered.
- `long_press`  output  1  one-cycle pulse, at most once per press, registered.

## Operation
- **Synchroniser:** two flops, `sync1 ← button_raw` and `sync2 ← sync1`. The FSM sees only `sync2`. Both flops reset to 0.
- **Debounce counter:** width `$clog2(BOUNCE_TICKS)+1`.
- **Hold counter:** width `$clog2(LONG_TICKS)+1`, saturating.
- **FSM states:**
  - RELEASED: `sync2`=1 → MAYBE_PRESSED, debounce counter ← 0.
  - MAYBE_PRESSED:
    - `sync2`=0 → RELEASED; counter cleared, no output change.
    - `sync2`=1 and counter == BOUNCE_TICKS−1 → PRESSED; `button_out` ← 1, `pressed` ← 1, hold counter ← 0.
    - Otherwise counter++.
  - PRESSED:
    - `sync2`=0 → MAYBE_RELEASED, debounce counter ← 0.
    - Otherwise the hold counter increments until it saturates at LONG_TICKS.
    - On the edge where the hold counter == LONG_TICKS−1 (and `sync2`=1), `long_press` ← 1.
  - MAYBE_RELEASED:
    - `sync2`=1 → PRESSED. The hold counter is not cleared and continues, so a release glitch does not restart the long-press timer. No pulse.
    - `sync2`=0 and counter == BOUNCE_TICKS−1 → RELEASED; `button_out` ← 0, `released` ← 1.
    - Otherwise counter++.
- **Pulses:** all three pulses are high for exactly one cycle, then return to 0. At most one of them is high in any cycle.
- **Long press:** once per press. Saturation of the hold counter prevents a refire. The next press clears the hold counter on entry to PRESSED.
- **Unreachable states:** any unreachable encoding → RELEASED with all outputs 0.

## Timing
- **Reset:** while `rst`=0, immediately and asynchronously:
  - state = RELEASED;
  - `button_out`, `pressed`, `released`, `long_press` = 0;
  - both counters and both sync flops = 0.
- **Reset mid-press:** reset asserted during PRESSED drops `button_out` with no `released` pulse. After deassertion with the button still held, the press is re-qualified with full latency and produces `pressed`.
- **Acceptance latency:** let edge E be the first edge sampling the new raw level. `button_out` and the corresponding pulse change on edge E+2+BOUNCE_TICKS, provided the level stays stable throughout.
- **Minimal window:** with BOUNCE_TICKS=1, MAYBE_* lasts one cycle, so latency = 3 edges.
- **Long-press timing:** `long_press` fires LONG_TICKS edges after the edge that raised `button_out`. Glitch time spent in MAYBE_RELEASED counts toward LONG_TICKS.
- **Rejected bounces:** any instability shorter than BOUNCE_TICKS cycles (after synchronisation) produces no output change and no pulse.
- **No handshake:** consumers must sample the pulses every cycle.

## Test plan
Bench parameters: BOUNCE_TICKS=50, LONG_TICKS=200, 12 MHz clock. Reset is driven low for 2 cycles, then high, unless stated otherwise.
1. **Reset values:** hold `rst`=0 with `button_raw`=1 → all outputs stay 0 and no pulse occurs. Release `rst` → `button_out` rises exactly 52 edges after the first sampling edge, and `pressed` is high for that single cycle.
2. **Bounce rejection:** `button_raw` toggles every 10 cycles for 100 cycles, then returns to 0 → `button_out` stays 0 and `pressed`/`released` never assert.
3. **Release glitch:** press stable for 100 cycles, then `button_raw`=0 for 30 cycles, then 1 → `button_out` stays 1, with no `released` and no second `pressed`.
4. **Long press:** hold `button_raw` for 400 cycles → `long_press` fires exactly once, 200 edges after `button_out` rose. Release → `released` fires 52 edges after the falling sample, with no further `long_press`.
5. **Short press:** hold for 100 cycles, then release → `pressed` and `released` each fire once and `long_press` never fires. A second identical press produces an identical pulse sequence.
6. **Reset mid-press:** assert `rst`=0 while in PRESSED → `button_out` drops in the same timestep, with no `released` pulse. Deassert with the button still held → `pressed` fires 52 edges later.
